// File: rtl/timing_counter.sv
// Triple-redundant bit-time / phase-time counter with bitwise 2-of-3 voting.
// Every copy is reloaded from the vote each cycle, so a single upset scrubs itself out.
module timing_counter #(
  parameter int NBITS  = 14,
  parameter int NPHASE = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ADV1,
  input  logic       ADV2,
  input  logic       ADV3,
  input  logic       SYNC,
  input  logic       ERR_CLR,
  output logic [3:0] BT,
  output logic [1:0] PT,
  output logic       BT_FIRST,
  output logic       BT_LAST,
  output logic       CYC_END,
  output logic [2:0] DIS
);

  localparam logic [3:0] BT_MAX = 4'(NBITS - 1);
  localparam logic [1:0] PT_MAX = 2'(NPHASE - 1);

  logic [2:0][3:0] bt_q, bt_d;
  logic [2:0][1:0] pt_q, pt_d;
  logic [2:0]      dis_q, dis_d;
  logic            cyc_end_q, cyc_end_d;

  logic [2:0] adv;
  logic [3:0] vbt, adv_bt, nvbt;
  logic [1:0] vpt, adv_pt, nvpt;

  function automatic logic [3:0] maj4(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [1:0] maj2(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    adv    = {ADV3, ADV2, ADV1};
    vbt    = maj4(bt_q[0], bt_q[1], bt_q[2]);
    vpt    = maj2(pt_q[0], pt_q[1], pt_q[2]);
    adv_bt = 4'd0;
    adv_pt = vpt;
    bt_d   = '0;
    pt_d   = '0;
    dis_d  = '0;

    // Out-of-range votes fall into the wrap branch, which restores a legal count.
    if (vbt < BT_MAX) begin
      adv_bt = vbt + 4'd1;
    end else begin
      adv_bt = 4'd0;
      adv_pt = (vpt < PT_MAX) ? vpt + 2'd1 : 2'd0;
    end

    for (int i = 0; i < 3; i++) begin
      if (SYNC) begin
        bt_d[i] = 4'd0;
        pt_d[i] = 2'd0;
      end else if (adv[i]) begin
        bt_d[i] = adv_bt;
        pt_d[i] = adv_pt;
      end else begin
        bt_d[i] = vbt;
        pt_d[i] = vpt;
      end
      dis_d[i] = ({bt_q[i], pt_q[i]} != {vbt, vpt}) | (dis_q[i] & ~ERR_CLR);
    end

    // The end-of-cycle pulse follows the vote, so lone or straggling strobes never fire it.
    nvbt      = maj4(bt_d[0], bt_d[1], bt_d[2]);
    nvpt      = maj2(pt_d[0], pt_d[1], pt_d[2]);
    cyc_end_d = !SYNC && (vbt == BT_MAX) && (vpt == PT_MAX) &&
                (nvbt == 4'd0) && (nvpt == 2'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bt_q      <= '0;
      pt_q      <= '0;
      dis_q     <= '0;
      cyc_end_q <= 1'b0;
    end else begin
      bt_q      <= bt_d;
      pt_q      <= pt_d;
      dis_q     <= dis_d;
      cyc_end_q <= cyc_end_d;
    end
  end

  assign BT       = vbt;
  assign PT       = vpt;
  assign BT_FIRST = (vbt == 4'd0);
  assign BT_LAST  = (vbt == BT_MAX);
  assign CYC_END  = cyc_end_q;
  assign DIS      = dis_q;

endmodule
